// File: rtl/nibble_link_pkg.sv
// Definitions shared by both directions of the 4-bit nibble link.
// The link state encoding and the link geometry live here.
package nibble_link_pkg;

    localparam int LINK_DATA_W  = 32;
    localparam int LINK_NIB_W   = 4;
    localparam int LINK_NUM_NIB = LINK_DATA_W / LINK_NIB_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } link_state_e;

endpackage

// File: rtl/pcpi_result_tx_if.sv
// Signal bundle for the result transmitter.
// It carries the PCPI result strobe side and the host nibble side.
interface pcpi_result_tx_if #(
    parameter int DATA_W = 32,
    parameter int NIB_W  = 4
);
    logic              pcpi_ready;
    logic              pcpi_wr;
    logic [DATA_W-1:0] pcpi_rd;
    logic [NIB_W-1:0]  tx_nibble;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ack;
    logic              busy;
    logic              overrun;

    // The transmitter's view of the bundle.
    modport master (
        input  pcpi_ready, pcpi_wr, pcpi_rd, tx_ack,
        output tx_nibble, tx_valid, tx_last, busy, overrun
    );

    // The view used by the coprocessor and the host.
    modport slave (
        output pcpi_ready, pcpi_wr, pcpi_rd, tx_ack,
        input  tx_nibble, tx_valid, tx_last, busy, overrun
    );
endinterface

// File: rtl/pcpi_result_tx.sv
// Returns PCPI results to the host as 8 nibbles, least-significant nibble first.
// Each nibble goes out through a four-phase valid/ack handshake.
module pcpi_result_tx
    import nibble_link_pkg::*;
#(
    parameter int DATA_W = LINK_DATA_W,
    parameter int NIB_W  = LINK_NIB_W
) (
    input  logic               clk,
    input  logic               rst_n,
    pcpi_result_tx_if.master   bus
);

    localparam int NUM_NIB = DATA_W / NIB_W;
    localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NIB - 1);

    link_state_e       state_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [NIB_W-1:0]  nibble_reg;
    logic              valid_reg;
    logic              last_reg;
    logic              busy_reg;
    logic              overrun_reg;

    logic              capture;
    logic [DATA_W-1:0] shreg_next;
    logic [CNT_W-1:0]  count_next;

    assign capture    = bus.pcpi_ready && bus.pcpi_wr;
    assign shreg_next = shreg_reg >> NIB_W;
    assign count_next = count_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            count_reg   <= '0;
            nibble_reg  <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            // A result arriving while a word is still in flight is lost.
            if (state_reg != IDLE && capture) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (capture) begin
                        shreg_reg  <= bus.pcpi_rd;
                        count_reg  <= '0;
                        nibble_reg <= bus.pcpi_rd[NIB_W-1:0];
                        valid_reg  <= 1'b1;
                        last_reg   <= (LAST_IDX == '0);
                        busy_reg   <= 1'b1;
                        state_reg  <= PRESENT;
                    end
                end

                PRESENT: begin
                    if (bus.tx_ack) begin
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                        state_reg <= RELEASE;
                    end
                end

                RELEASE: begin
                    // Valid stays low here for at least one cycle, whatever ack does.
                    if (!bus.tx_ack) begin
                        if (count_reg == LAST_IDX) begin
                            last_reg  <= 1'b0;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            shreg_reg  <= shreg_next;
                            count_reg  <= count_next;
                            nibble_reg <= shreg_next[NIB_W-1:0];
                            valid_reg  <= 1'b1;
                            last_reg   <= (count_next == LAST_IDX);
                            state_reg  <= PRESENT;
                        end
                    end
                end

                default: begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_nibble = nibble_reg;
    assign bus.tx_valid  = valid_reg;
    assign bus.tx_last   = last_reg;
    assign bus.busy      = busy_reg;
    assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_pcpi_result_tx.sv
// Directed bench for pcpi_result_tx. Expected nibbles are queued when a word
// is strobed in and are popped as the host model accepts each nibble.
module tb_pcpi_result_tx;

    logic clk = 1'b0;
    logic rst_n;
    int   compares = 0;
    int   fails = 0;
    int   cyc = 0;

    typedef struct {
        logic [3:0] nib;
        logic       last;
    } exp_t;

    exp_t sb[$];

    pcpi_result_tx_if #(.DATA_W(32), .NIB_W(4)) bus ();

    pcpi_result_tx #(.DATA_W(32), .NIB_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.nib  = w[4*k +: 4];
            e.last = (k == 7);
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; leaves the strobe high across exactly one posedge.
    task automatic strobe(input logic [31:0] w, input logic wr, input bit expect_tx);
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = wr;
        bus.pcpi_rd    = w;
        if (expect_tx) push_word(w);
        @(negedge clk);
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        $display("strobe rd=%08h wr=%0b queued=%0d", w, wr, sb.size());
    endtask

    // Host side of one nibble: wait for valid, stall, hold ack, then release.
    task automatic host_nibble(input int stall, input int hold);
        int         n;
        exp_t       e;
        logic [3:0] held;
        n = 0;
        while (!bus.tx_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("valid_wait", 32'(bus.tx_valid), 32'd1);
        if (!bus.tx_valid) return;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("nibble", 32'(bus.tx_nibble), 32'(e.nib));
        check("last", 32'(bus.tx_last), 32'(e.last));
        $display("nibble %h last=%0b (expected %h last=%0b)", bus.tx_nibble, bus.tx_last, e.nib, e.last);
        held = bus.tx_nibble;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.tx_valid), 32'd1);
            check("stall_nibble", 32'(bus.tx_nibble), 32'(held));
        end
        bus.tx_ack = 1'b1;
        @(negedge clk);
        check("ack_valid_low", 32'(bus.tx_valid), 32'd0);
        check("ack_last_low", 32'(bus.tx_last), 32'd0);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid_low", 32'(bus.tx_valid), 32'd0);
        end
        bus.tx_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  t0;
        bit  saw_valid;
        rst_n          = 1'b0;
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_rd    = '0;
        bus.tx_ack     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_nibble", 32'(bus.tx_nibble), 32'd0);
        check("rst_last", 32'(bus.tx_last), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic word with zero-wait host.
        t0 = cyc;
        strobe(32'hDEADBEEF, 1'b1, 1'b1);
        check("latency_valid", 32'(bus.tx_valid), 32'd1);
        check("latency_busy", 32'(bus.busy), 32'd1);
        repeat (8) host_nibble(0, 1);
        check("basic_cycles", 32'(cyc - t0), 32'd17);
        check("basic_busy_done", 32'(bus.busy), 32'd0);
        check("basic_sb_empty", 32'(sb.size()), 32'd0);

        // Stalled host on nibble 3.
        strobe(32'h76543210, 1'b1, 1'b1);
        repeat (3) host_nibble(0, 1);
        host_nibble(20, 1);
        repeat (4) host_nibble(0, 1);
        check("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Ack held high after nibble 0.
        strobe(32'hA5C30F96, 1'b1, 1'b1);
        host_nibble(0, 5);
        check("nib1_latency", 32'(bus.tx_valid), 32'd1);
        repeat (7) host_nibble(0, 1);
        check("ackhold_sb_empty", 32'(sb.size()), 32'd0);

        // Overrun during nibble 4.
        strobe(32'hCAFEF00D, 1'b1, 1'b1);
        repeat (4) host_nibble(0, 1);
        check("ovr_nib4_valid", 32'(bus.tx_valid), 32'd1);
        strobe(32'h12345678, 1'b1, 1'b0);
        check("ovr_set", 32'(bus.overrun), 32'd1);
        check("ovr_busy", 32'(bus.busy), 32'd1);
        repeat (4) host_nibble(0, 1);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        check("ovr_sb_empty", 32'(sb.size()), 32'd0);
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.tx_valid) saw_valid = 1'b1;
        end
        check("ovr_word_dropped", 32'(saw_valid), 32'd0);
        check("ovr_still_set", 32'(bus.overrun), 32'd1);

        // pcpi_ready without pcpi_wr is ignored.
        strobe(32'h5555AAAA, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("qual_busy", 32'(bus.busy), 32'd0);
        check("qual_valid", 32'(bus.tx_valid), 32'd0);

        // Reset while nibble 5 is presented.
        strobe(32'h0BADF00D, 1'b1, 1'b1);
        repeat (5) host_nibble(0, 1);
        check("rst5_valid_before", 32'(bus.tx_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(bus.tx_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_overrun", 32'(bus.overrun), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);

        strobe(32'h00000001, 1'b1, 1'b1);
        repeat (8) host_nibble(0, 1);
        check("one_busy_done", 32'(bus.busy), 32'd0);

        // Back-to-back: strobe on the first IDLE cycle.
        strobe(32'h9E3779B9, 1'b1, 1'b1);
        check("b2b_valid", 32'(bus.tx_valid), 32'd1);
        check("b2b_overrun", 32'(bus.overrun), 32'd0);
        repeat (8) host_nibble(0, 1);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        check("b2b_overrun_end", 32'(bus.overrun), 32'd0);
        check("b2b_busy_done", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

// File: doc/pcpi_result_tx.md
Name: pcpi_result_tx

Overview:
- Transmit side of the 4-bit nibble link: returns PCPI coprocessor results to the off-chip host.
- Captures the 32-bit `pcpi_rd` when the coprocessor signals `pcpi_ready` with `pcpi_wr`.
- Serializes the word as 8 nibbles, least-significant nibble first, using a valid/ack four-phase handshake.
- Mirrors the existing instruction receiver: nibble k carries bits [4k+3:4k].

Parameters:
- DATA_W, 32, width of the captured result word.
- NIB_W, 4, nibble width on the link.
- NUM_NIB, DATA_W/NIB_W (8), derived localparam; not overridable.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- pcpi_ready  input  1  coprocessor result strobe (single-cycle pulse)
- pcpi_wr  input  1  result is to be written back; qualifies pcpi_ready
- pcpi_rd  input  DATA_W  result word, valid when pcpi_ready=1
- tx_nibble  output  NIB_W  current nibble to host, registered
- tx_valid  output  1  nibble on tx_nibble is valid, registered
- tx_last  output  1  high with tx_valid on final nibble (index NUM_NIB-1)
- tx_ack  input  1  host acknowledge (level, four-phase)
- busy  output  1  high whenever state != IDLE
- overrun  output  1  sticky: result dropped because block was busy

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, tx_valid=0, tx_nibble=0, tx_last=0, busy=0, overrun=0, shift register=0, count=0.
- Reset mid-transfer aborts immediately and discards the word; the host sees tx_valid fall on the next edge.

States:
- IDLE:
  - If pcpi_ready&&pcpi_wr: load shreg<=pcpi_rd, count<=0, tx_nibble<=pcpi_rd[3:0], tx_valid<=1, go to PRESENT.
  - Latency: tx_valid is high in the cycle after the strobe.
  - pcpi_ready with pcpi_wr=0 is ignored.
  - tx_ack is ignored in IDLE.
- PRESENT:
  - tx_valid=1; tx_nibble is held stable.
  - On tx_ack=1 (sampled): tx_valid<=0, go to RELEASE.
  - Stays in PRESENT indefinitely while tx_ack=0. There is no timeout.
- RELEASE:
  - tx_valid=0; waits for tx_ack=0.
  - On tx_ack=0 with count==NUM_NIB-1: go to IDLE, tx_last<=0.
  - On tx_ack=0 otherwise: shreg>>=NIB_W, count++, tx_nibble<=next nibble, tx_valid<=1, go to PRESENT.
  - Minimum one cycle with tx_valid low between nibbles, even if the host drops ack in the same cycle.

Rules:
- tx_last = tx_valid && count==NUM_NIB-1, registered alongside tx_valid.
- Minimum transfer time: 1 + 2*NUM_NIB cycles with zero-wait ack (ack high the cycle after valid, low the next).
- count is 3 bits and never wraps. The transition at NUM_NIB-1 exits to IDLE.
- pcpi_ready&&pcpi_wr in any non-IDLE state, including the final RELEASE cycle:
  - The word is dropped and overrun<=1.
  - The in-flight transfer is unaffected.
  - overrun clears only on reset.
- A new capture is accepted on the first IDLE cycle after the transfer completes.
- tx_ack already high when a new word is captured: PRESENT sees it and moves to RELEASE after one cycle of valid. This is legal per four-phase protocol.

Decomposition:
- Shared package `nibble_link_pkg`:
  - state enum {IDLE, PRESENT, RELEASE}
  - NIB_W, NUM_NIB constants
  - Also to be adopted by the instruction receiver.
- Single module; the shift register and counter are inline. No sub-module is warranted.

Test Plan:
- Basic word:
  - Stimulus: pcpi_rd=32'hDEADBEEF, pcpi_wr=1, one-cycle pcpi_ready; host acks each nibble with a 1-cycle delay.
  - Required: nibbles F,E,E,B,D,A,E,D in order; tx_last only on the 8th; busy low after final release; first tx_valid one cycle after the strobe.
- Stalled host:
  - Stimulus: hold tx_ack=0 for 20 cycles on nibble 3, then ack.
  - Required: tx_valid and tx_nibble stable for all 20 cycles; no skipped or duplicated nibble.
- Ack held high:
  - Stimulus: host keeps tx_ack=1 for 5 cycles after nibble 0.
  - Required: tx_valid stays 0 until ack drops; nibble 1 is presented one cycle later; each nibble is counted once.
- Overrun:
  - Stimulus: second pcpi_ready/pcpi_wr with rd=32'h12345678 during nibble 4 of 32'hCAFEF00D.
  - Required: 32'hCAFEF00D completes intact; overrun=1 and stays set; 32'h12345678 is never transmitted.
- Qualifier and reset:
  - Stimulus: pcpi_ready with pcpi_wr=0.
  - Required: no transfer and busy stays 0.
  - Stimulus: rst_n low at nibble 5.
  - Required: next edge gives tx_valid=0, busy=0, overrun=0; a subsequent word 32'h00000001 sends 1,0,0,0,0,0,0,0.
- Back-to-back:
  - Stimulus: a new strobe on the first IDLE cycle after completion.
  - Required: accepted with no overrun.
